// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline hazard controller.
//   state_t           - controller FSM state (RUN / MEMW / TRAP)
//   TRAP_CYCLES_DEF   - default trap-drain length in cycles
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MEMW = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  localparam int TRAP_CYCLES_DEF = 2;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// pipe_hazard_cmp: combinational load-use hazard detector.
// Ports:
//   id_rs1, id_rs2         in  decode-stage source register indices
//   id_use_rs1, id_use_rs2 in  which decode sources are actually read
//   ex_valid, ex_is_load   in  execute stage holds a valid load
//   ex_rd                  in  execute-stage destination index
//   hazard                 out decode reads the register the load is still fetching
module pipe_hazard_cmp (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hazard = ex_valid && ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/trap controller for a 4-stage in-order pipeline.
// Optional build macro: PIPE_CTRL_PERF_EN compiles in the performance counters;
// without it stall_cycles/flush_events are tied to zero.
// Ports:
//   clk, nrst                         clock, synchronous active-low reset
//   id_rs1/rs2, id_use_rs1/rs2        decode-stage source operands
//   ex_valid, ex_rd, ex_is_load       execute-stage instruction info
//   ex_redirect                       taken branch/jump resolved in execute
//   mem_req, mem_ack                  data-memory access outstanding / done
//   trap_req, trap_ack                trap request / one-cycle acceptance pulse
//   pc/fd/de/em_stall                 hold PC and pipeline registers
//   fd/de/em_flush                    zero pipeline registers
//   stall_cycles, flush_events        performance counters
//
// state | meaning
// RUN   | normal flow; trap, memory wait, redirect, load-use handled here
// MEMW  | data access outstanding, whole pipeline frozen until mem_ack
// TRAP  | draining the pipeline for drain_cnt+1 more cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TRAP_CYCLES = TRAP_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        trap_req,
  output logic        trap_ack,
  output logic        pc_stall,
  output logic        fd_stall,
  output logic        de_stall,
  output logic        em_stall,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam logic [3:0] DRAIN_INIT = 4'(TRAP_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] drain_cnt;
  logic       load_use;

  pipe_hazard_cmp u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .hazard     (load_use)
  );

  // Outputs are decoded from the current state and this cycle's inputs so the
  // pipeline reacts in the same cycle. Reset forces every control low.
  always_comb begin
    trap_ack  = 1'b0;
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    de_stall  = 1'b0;
    em_stall  = 1'b0;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    em_flush  = 1'b0;
    state_nxt = state;
    if (nrst) begin
      case (state)
        ST_RUN: begin
          if (trap_req) begin
            trap_ack  = 1'b1;
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            em_flush  = 1'b1;
            state_nxt = ST_TRAP;
          end else if (mem_req && !mem_ack) begin
            pc_stall  = 1'b1;
            fd_stall  = 1'b1;
            de_stall  = 1'b1;
            em_stall  = 1'b1;
            state_nxt = ST_MEMW;
          end else if (ex_valid && ex_redirect) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
          end else if (load_use) begin
            // Hold fetch/decode and push a bubble into execute.
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
          end
        end
        ST_MEMW: begin
          // Pending traps wait here; the access is never aborted.
          if (mem_ack) begin
            state_nxt = ST_RUN;
          end else begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
          end
        end
        ST_TRAP: begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
          em_flush = 1'b1;
          if (drain_cnt == 4'd0) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= ST_RUN;
      drain_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && trap_req) begin
        drain_cnt <= DRAIN_INIT;
      end else if (state == ST_TRAP && drain_cnt != 4'd0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (pc_stall) stall_cnt <= stall_cnt + 32'd1;
      if (fd_flush || de_flush || em_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_events = flush_cnt;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic for pipe_ctrl,
// checked every cycle against a behavioural model of the control rules.
module tb_pipe_ctrl;

  localparam int TC = 2;

  logic        clk;
  logic        nrst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_redirect;
  logic        mem_req, mem_ack, trap_req;
  logic        trap_ack, pc_stall, fd_stall, de_stall, em_stall;
  logic        fd_flush, de_flush, em_flush;
  logic [31:0] stall_cycles, flush_events;

  int checks = 0;
  int errors = 0;

  // Model state: is a memory wait pending, how many drain cycles remain.
  bit          m_mem_wait = 0;
  int          m_drain = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  pipe_ctrl #(.TRAP_CYCLES(TC)) dut (
    .clk(clk), .nrst(nrst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .trap_req(trap_req), .trap_ack(trap_ack),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .de_stall(de_stall), .em_stall(em_stall),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {trap_ack, pc, fd, de, em stall, fd, de, em flush}
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_STALL = 8'b0111_1000;
  localparam logic [7:0] O_TRAP  = 8'b1000_0111;
  localparam logic [7:0] O_DRAIN = 8'b0000_0111;
  localparam logic [7:0] O_REDIR = 8'b0000_0110;
  localparam logic [7:0] O_LU    = 8'b0110_0010;

  function automatic bit load_use_now();
    if (!(ex_valid && ex_is_load) || ex_rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  endfunction

  // Expected outputs this cycle; also advances the model to the next cycle.
  function automatic logic [7:0] model_cycle();
    logic [7:0] o;
    o = O_NONE;
    if (!nrst) begin
      m_mem_wait = 0;
      m_drain    = 0;
      return o;
    end
    if (m_drain > 0) begin
      o = O_DRAIN;
      m_drain--;
    end else if (m_mem_wait) begin
      if (mem_ack) m_mem_wait = 0;
      else o = O_STALL;
    end else if (trap_req) begin
      o = O_TRAP;
      m_drain = TC;
    end else if (mem_req && !mem_ack) begin
      o = O_STALL;
      m_mem_wait = 1;
    end else if (ex_valid && ex_redirect) begin
      o = O_REDIR;
    end else if (load_use_now()) begin
      o = O_LU;
    end
    return o;
  endfunction

  // Called #1 after a rising edge with inputs set; checks at the falling edge
  // and returns #1 after the next rising edge.
  task automatic step(input string nm, input bit lit_en, input logic [7:0] lit);
    logic [7:0] exp_o, act_o;
    logic [31:0] exp_sc, exp_fe;
    bit rst_now;
    @(negedge clk);
    rst_now = !nrst;
`ifdef PIPE_CTRL_PERF_EN
    exp_sc = m_stall;
    exp_fe = m_flush;
`else
    exp_sc = 32'd0;
    exp_fe = 32'd0;
`endif
    exp_o = model_cycle();
    act_o = {trap_ack, pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush, em_flush};
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b at %0t", nm, act_o, exp_o, $time);
    end
    if (lit_en) begin
      checks++;
      if (act_o !== lit || exp_o !== lit) begin
        errors++;
        $display("FAIL %s literal: dut %b model %b required %b", nm, act_o, exp_o, lit);
      end
    end
    checks++;
    if (stall_cycles !== exp_sc || flush_events !== exp_fe) begin
      errors++;
      $display("FAIL %s counters: got %h/%h expected %h/%h", nm, stall_cycles, flush_events,
               exp_sc, exp_fe);
    end
    if (rst_now) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (exp_o[6]) m_stall = m_stall + 32'd1;
      if (|exp_o[2:0]) m_flush = m_flush + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_redirect = 0;
    mem_req = 0; mem_ack = 0; trap_req = 0;
  endtask

  task automatic load_x5_rs1();
    ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
  endtask

  initial begin
    idle();
    nrst = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 1, O_NONE);
    nrst = 1'b1;
    step("idle", 1, O_NONE);

    // Load-use on x5, then normal, then a load to x0 must not stall.
    load_x5_rs1();
    step("lu_x5", 1, O_LU);
    idle();
    step("lu_after", 1, O_NONE);
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step("lu_x0", 1, O_NONE);
    idle(); ex_valid = 1; ex_is_load = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1;
    step("lu_rs2", 1, O_LU);
    id_use_rs2 = 0;
    step("lu_rs2_unused", 1, O_NONE);

    // Memory wait: three stalled cycles then release.
    idle(); mem_req = 1;
    step("mem_w1", 1, O_STALL);
    load_x5_rs1(); ex_redirect = 1;
    step("mem_w2", 1, O_STALL);
    step("mem_w3", 1, O_STALL);
    mem_ack = 1;
    step("mem_ack", 1, O_NONE);
    idle(); mem_req = 1; mem_ack = 1;
    step("mem_same_cycle", 1, O_NONE);

    // Trap deferred behind memory wait.
    idle(); mem_req = 1;
    step("mt_w1", 1, O_STALL);
    trap_req = 1;
    step("mt_w2", 1, O_STALL);
    mem_ack = 1;
    step("mt_ack", 1, O_NONE);
    mem_req = 0; mem_ack = 0;
    step("mt_trap", 1, O_TRAP);
    step("mt_drain1", 1, O_DRAIN);
    step("mt_drain2", 1, O_DRAIN);
    trap_req = 0;
    step("mt_done", 1, O_NONE);

    // Redirect beats load-use.
    idle(); load_x5_rs1(); ex_redirect = 1;
    step("redir_lu", 1, O_REDIR);
    idle();
    step("redir_after", 1, O_NONE);

    // Reset in the middle of a trap drain.
    trap_req = 1;
    step("rt_trap", 1, O_TRAP);
    trap_req = 0; nrst = 0;
    step("rt_reset", 1, O_NONE);
    nrst = 1;
    step("rt_after", 1, O_NONE);

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom);
      id_use_rs2  = 1'($urandom);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_is_load  = 1'($urandom);
      ex_redirect = ($urandom_range(0, 5) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ack     = ($urandom_range(0, 2) == 0);
      trap_req    = ($urandom_range(0, 15) == 0);
      nrst        = ($urandom_range(0, 63) != 0);
      step("random", 0, O_NONE);
    end
    nrst = 1;
    idle();
    step("rand_end", 0, O_NONE);

`ifdef PIPE_CTRL_PERF_EN
    // Stall counter wrap from all-ones.
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_stall = 32'hFFFF_FFFF;
    mem_req = 1;
    step("wrap_stall", 1, O_STALL);
    mem_ack = 1;
    step("wrap_ack", 1, O_NONE);
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL wrap_value: got %h expected 00000000", stall_cycles);
    end
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TRAP_CYCLES, default 2, SHALL set trap-drain length in cycles (legal 1..15).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 nrst  in  1  SHALL be the reset: synchronous, active-low.
REQ-004 id_rs1, id_rs2  in  5 each  SHALL be the decode-stage source register indices.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  SHALL mark which decode sources are actually read.
REQ-006 ex_valid  in  1  SHALL be the is_a_inst output of the D/E pipeline register.
REQ-007 ex_rd  in  5  SHALL be the D/E destination index; ex_is_load  in  1  SHALL mark a load in execute.
REQ-008 ex_redirect  in  1  SHALL mark a taken branch/jump resolved in execute.
REQ-009 mem_req  in  1  SHALL mark an outstanding data-memory access; mem_ack  in  1  SHALL mark its completion.
REQ-010 trap_req  in  1  SHALL be the CSR unit's trap/interrupt request; trap_ack  out  1  SHALL pulse one cycle on trap acceptance.
REQ-011 pc_stall, fd_stall, de_stall, em_stall  out  1 each  SHALL hold the PC and the F/D, D/E, E/M registers.
REQ-012 fd_flush, de_flush, em_flush  out  1 each  SHALL zero the F/D, D/E, E/M registers.
REQ-013 stall_cycles, flush_events  out  32 each  SHALL be performance counters (REQ-031).

Function
REQ-014 FSM states SHALL be RUN, MEMW, TRAP; all outputs SHALL be decoded from state plus current-cycle inputs (zero-latency control).
REQ-015 Per-cycle priority in RUN SHALL be: trap > memory wait > redirect > load-use.
REQ-016 RUN, trap_req=1: trap_ack=1, fd/de/em_flush=1, all stalls=0, next TRAP with drain counter = TRAP_CYCLES-1.
REQ-017 TRAP: fd/de/em_flush=1, stalls=0, trap_req ignored; counter decrements each cycle; at counter 0 next RUN.
REQ-018 RUN, mem_req=1 and mem_ack=0 (no trap): pc/fd/de/em_stall=1, flushes=0, next MEMW.
REQ-019 MEMW: all four stalls=1 while mem_ack=0; cycle with mem_ack=1 SHALL deassert all stalls and go to RUN.
REQ-020 mem_req=1 with mem_ack=1 in the same RUN cycle SHALL cause no stall and no state change.
REQ-021 trap_req during MEMW SHALL be deferred (memory access never aborted); it is taken in the first RUN cycle if still asserted.
REQ-022 RUN, ex_valid & ex_redirect (no trap/memory wait): fd_flush=1, de_flush=1 for that cycle only; stalls=0.
REQ-023 Load-use hazard = ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-024 Load-use in RUN (no higher-priority event): pc_stall=1, fd_stall=1, de_flush=1 (bubble), em_stall=0.
REQ-025 Redirect and load-use in the same cycle: redirect wins; no stall asserted.
REQ-026 Redirect/load-use concurrent with memory wait SHALL be suppressed; the frozen execute stage re-presents them after release.
REQ-027 A stall and a flush SHALL never be asserted on the same pipeline register in the same cycle.

Reset
REQ-028 nrst=0 at a clock edge SHALL force state RUN, drain counter 0, counters 0, from any state including MEMW/TRAP mid-operation.
REQ-029 While nrst=0, every stall, flush and trap_ack output SHALL be 0.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN SHALL compile the performance counters in.
REQ-031 With the macro: stall_cycles increments each cycle pc_stall=1; flush_events increments each cycle any flush=1; both wrap modulo 2^32. Without it: both ports present and tied to 0.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold the FSM state enum and the default TRAP_CYCLES constant.
REQ-033 Load-use comparison SHALL be the combinational sub-module pipe_hazard_cmp; FSM and counters stay in pipe_ctrl.

Verification
REQ-034 Load x5 in EX, ID reads rs1=5 -> one cycle pc_stall=fd_stall=de_flush=1, then normal; rd=0 load -> no stall.
REQ-035 mem_req=1, mem_ack low 3 cycles then high -> stalls high exactly 3 cycles, state RUN after ack.
REQ-036 trap_req during MEMW -> no trap_ack until mem_ack; then trap_ack one cycle, flushes for TRAP_CYCLES=2 cycles.
REQ-037 ex_redirect with simultaneous load-use -> fd_flush=de_flush=1, no stalls, single cycle.
REQ-038 nrst low during TRAP cycle 1 -> next cycle all outputs 0, state RUN; with PIPE_CTRL_PERF_EN, counters read 0.
REQ-039 PIPE_CTRL_PERF_EN, stall_cycles preloaded 32'hFFFFFFFF via force, one stall cycle -> wraps to 0.
